// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared BCD constants, digit type and nibble clamp helper
//                for the multi-digit BCD counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Limit a raw nibble to a legal BCD digit; codes A..F become 9.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_cell
//  Description : Combinational next-state logic for one BCD digit. The
//                enables arrive already gated by the lower-digit prefix
//                chain, so the cell only steps or rolls its own digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] cur,
  input  logic       up_en,
  input  logic       dn_en,
  output logic [3:0] nxt,
  output logic       is_max,
  output logic       is_min
);

  assign is_max = (cur == BCD_MAX);
  assign is_min = (cur == BCD_ZERO);

  // Step up with 9->0 roll, step down with 0->9 roll, otherwise hold.
  always_comb begin
    nxt = cur;
    if (up_en && !dn_en) begin
      nxt = is_max ? BCD_ZERO : (cur + 4'd1);
    end else if (dn_en && !up_en) begin
      nxt = is_min ? BCD_MAX : (cur - 4'd1);
    end
  end

endmodule : bcd_digit_cell
`default_nettype wire

// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_n
//  Description : DIGITS-wide BCD up/down counter with edge or level count
//                inputs, synchronous parallel load (digits clamped to 9),
//                carry/borrow pulses and optional saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit EDGE_IN  = 1'b1,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   val,
  output logic                  carry,
  output logic                  borrow,
  output logic                  zero
);

  localparam int c_W = 4 * DIGITS;

  logic             w_up_req;
  logic             w_dn_req;
  logic             w_up;
  logic             w_dn;
  logic [DIGITS:0]  w_all_max;
  logic [DIGITS:0]  w_all_min;
  logic [DIGITS-1:0] w_is_max;
  logic [DIGITS-1:0] w_is_min;
  logic [c_W-1:0]   w_cell_nxt;
  logic [c_W-1:0]   w_load_clamped;
  logic [c_W-1:0]   w_next_val;
  logic             w_overflow;
  logic             w_underflow;

  // ---------------------------------------------------------------------
  // Count strobe generation
  // ---------------------------------------------------------------------
  if (EDGE_IN) begin : g_edge_in
    logic r_s1_inc, r_s2_inc, r_s1_dec, r_s2_dec;

    // Two-flop synchronisers; the second stage doubles as the edge history.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1_inc <= 1'b0;
        r_s2_inc <= 1'b0;
        r_s1_dec <= 1'b0;
        r_s2_dec <= 1'b0;
      end else begin
        r_s1_inc <= inc;
        r_s2_inc <= r_s1_inc;
        r_s1_dec <= dec;
        r_s2_dec <= r_s1_dec;
      end
    end

    assign w_up_req = r_s1_inc & ~r_s2_inc;
    assign w_dn_req = r_s1_dec & ~r_s2_dec;
  end else begin : g_level_in
    assign w_up_req = inc;
    assign w_dn_req = dec;
  end

  // Simultaneous up and down cancel to a no-op.
  assign w_up = w_up_req & ~w_dn_req;
  assign w_dn = w_dn_req & ~w_up_req;

  // ---------------------------------------------------------------------
  // Digit cascade: digit i moves only when every lower digit rolls.
  // ---------------------------------------------------------------------
  assign w_all_max[0] = 1'b1;
  assign w_all_min[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .cur    (val[4*i +: 4]),
      .up_en  (w_up & w_all_max[i]),
      .dn_en  (w_dn & w_all_min[i]),
      .nxt    (w_cell_nxt[4*i +: 4]),
      .is_max (w_is_max[i]),
      .is_min (w_is_min[i])
    );

    assign w_all_max[i+1] = w_all_max[i] & w_is_max[i];
    assign w_all_min[i+1] = w_all_min[i] & w_is_min[i];
    assign w_load_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
  end

  assign w_overflow  = w_up & w_all_max[DIGITS];
  assign w_underflow = w_dn & w_all_min[DIGITS];

  // Saturating builds hold the value at the limits instead of wrapping.
  always_comb begin
    w_next_val = w_cell_nxt;
    if (SATURATE && (w_overflow || w_underflow)) begin
      w_next_val = val;
    end
  end

  // Output register: reset, then load, then count; zero tracks next val.
  always_ff @(posedge clk) begin
    if (reset) begin
      val    <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      zero   <= 1'b1;
    end else if (load) begin
      val    <= w_load_clamped;
      carry  <= 1'b0;
      borrow <= 1'b0;
      zero   <= (w_load_clamped == '0);
    end else begin
      val    <= w_next_val;
      carry  <= w_overflow;
      borrow <= w_underflow;
      zero   <= (w_next_val == '0);
    end
  end

endmodule : bcd_counter_n
`default_nettype wire

// File: tb/tb_bcd_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_counter_n
//  Description : Scoreboard bench for bcd_counter_n. Three instances cover
//                level/wrap, level/saturate and edge/wrap builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_n;

  typedef struct {
    int          cyc;
    logic [15:0] v;
    logic        c;
    logic        b;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  inc = '0;
  logic [2:0]  dec = '0;
  logic [2:0]  load = '0;
  logic [15:0] lv0 = '0, lv1 = '0, lv2 = '0;
  logic [15:0] val0, val1, val2;
  logic [2:0]  carry, borrow, zero;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  bcd_counter_n #(.DIGITS(4), .EDGE_IN(1'b0), .SATURATE(1'b0)) u_lvl (
    .clk(clk), .reset(reset), .inc(inc[0]), .dec(dec[0]), .load(load[0]),
    .load_val(lv0), .val(val0), .carry(carry[0]), .borrow(borrow[0]), .zero(zero[0]));

  bcd_counter_n #(.DIGITS(4), .EDGE_IN(1'b0), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .inc(inc[1]), .dec(dec[1]), .load(load[1]),
    .load_val(lv1), .val(val1), .carry(carry[1]), .borrow(borrow[1]), .zero(zero[1]));

  bcd_counter_n #(.DIGITS(4), .EDGE_IN(1'b1), .SATURATE(1'b0)) u_edge (
    .clk(clk), .reset(reset), .inc(inc[2]), .dec(dec[2]), .load(load[2]),
    .load_val(lv2), .val(val2), .carry(carry[2]), .borrow(borrow[2]), .zero(zero[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue the response expected after the coming clock edge.
  task automatic push(input int d, input logic [15:0] ev, input logic ec,
                      input logic eb, input logic ez);
    exp_t e;
    e.cyc = cyc + 1; e.v = ev; e.c = ec; e.b = eb; e.z = ez;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // One clock of stimulus to instance d (others idle) plus its expectation.
  task automatic step(input int d, input logic rst, input logic i, input logic dn,
                      input logic ld, input logic [15:0] lv, input logic [15:0] ev,
                      input logic ec, input logic eb, input logic ez);
    @(negedge clk);
    reset = rst;
    inc = '0; dec = '0; load = '0;
    inc[d] = i; dec[d] = dn; load[d] = ld;
    case (d)
      0:       lv0 = lv;
      1:       lv1 = lv;
      default: lv2 = lv;
    endcase
    push(d, ev, ec, eb, ez);
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpop(input int d, output exp_t e);
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  function automatic int qfront_cyc(input int d);
    case (d)
      0:       return q0[0].cyc;
      1:       return q1[0].cyc;
      default: return q2[0].cyc;
    endcase
  endfunction

  // Retire every expectation due this cycle for instance d.
  task automatic monitor(input int d, input logic [15:0] av, input logic ac,
                         input logic ab, input logic az);
    exp_t e;
    while (qsize(d) > 0 && qfront_cyc(d) <= cyc) begin
      qpop(d, e);
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL dut%0d stale@%0d: expectation for cycle %0d never checked", d, cyc, e.cyc);
      end else if (av !== e.v || ac !== e.c || ab !== e.b || az !== e.z) begin
        errors++;
        $display("FAIL dut%0d cyc%0d: got val=%h c=%b b=%b z=%b, want val=%h c=%b b=%b z=%b",
                 d, cyc, av, ac, ab, az, e.v, e.c, e.b, e.z);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0, val0, carry[0], borrow[0], zero[0]);
    monitor(1, val1, carry[1], borrow[1], zero[1]);
    monitor(2, val2, carry[2], borrow[2], zero[2]);
  end

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  initial begin
    // Reset state on all three instances.
    step(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    push(1, 16'h0000, 0, 0, 1);
    push(2, 16'h0000, 0, 0, 1);
    step(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);

    // Level mode: inc held 12 cycles counts to 12, zero drops on first count.
    for (int k = 1; k <= 12; k++)
      step(0, 0, 1, 0, 0, 16'h0000, to_bcd(k), 0, 0, 0);
    step(0, 0, 0, 0, 0, 16'h0000, 16'h0012, 0, 0, 0);

    // Wrap up and down with single-cycle carry/borrow.
    step(0, 0, 0, 0, 1, 16'h9999, 16'h9999, 0, 0, 0);
    step(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 1);
    step(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1);
    step(0, 0, 0, 1, 0, 16'h0000, 16'h9999, 0, 1, 0);
    step(0, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, 0);

    // Priority: load beats inc and clamps A->9; inc+dec cancel; reset beats load.
    step(0, 0, 1, 0, 1, 16'h12A4, 16'h1294, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16'h0050, 16'h0050, 0, 0, 0);
    step(0, 0, 1, 1, 0, 16'h0000, 16'h0050, 0, 0, 0);
    step(0, 1, 0, 0, 1, 16'h1234, 16'h0000, 0, 0, 1);

    // Cascade across several digits in one cycle.
    step(0, 0, 0, 0, 1, 16'h0199, 16'h0199, 0, 0, 0);
    step(0, 0, 1, 0, 0, 16'h0000, 16'h0200, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16'h1000, 16'h1000, 0, 0, 0);
    step(0, 0, 0, 1, 0, 16'h0000, 16'h0999, 0, 0, 0);

    // Saturating build: hold at limits while still pulsing carry/borrow.
    step(1, 0, 0, 0, 1, 16'h9999, 16'h9999, 0, 0, 0);
    step(1, 0, 1, 0, 0, 16'h0000, 16'h9999, 1, 0, 0);
    step(1, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, 0);
    step(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1);
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 1);
    step(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 1);
    step(1, 0, 0, 0, 1, 16'hF0B8, 16'h9098, 0, 0, 0);
    step(1, 0, 1, 0, 0, 16'h0000, 16'h9099, 0, 0, 0);

    // Edge mode: a 5-cycle inc pulse counts once, two edges after the rise.
    step(2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step(2, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      step(2, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      step(2, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0);
    // Edge-mode dec pulse back to zero, then another one borrowing to 9999.
    step(2, 0, 0, 1, 0, 16'h0000, 16'h0001, 0, 0, 0);
    step(2, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step(2, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step(2, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step(2, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step(2, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step(2, 0, 0, 1, 0, 16'h0000, 16'h9999, 0, 1, 0);
    step(2, 0, 0, 1, 0, 16'h0000, 16'h9999, 0, 0, 0);
    step(2, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 5 && (q0.size() + q1.size() + q2.size()) > 0; k++)
      @(negedge clk);
    @(negedge clk);
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q0.size() + q1.size() + q2.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bcd_counter_n
`default_nettype wire
